tff_count_seq: RTL

Sequencing controller for a bank of synchronous-reset T flip-flops. It computes the per-bit toggle enables that make the bank count up or down, load a value, hold, or wrap. Loads are done only through toggles, using t = q ^ target. It sits beside the flip-flop bank as its only driver and gives the rest of the design a start/stop/done-controlled counter.

---
 rtl/tff_seq_pkg.sv | 29 ++
 rtl/tff_sync_rst.sv | 17 +
 rtl/tff_count_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/tff_seq_pkg.sv
// Shared definitions for the T flip-flop counter sequencer: state codes, direction/mode
// constants and the per-bit count toggle function.
package tff_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t HOLD = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic UP       = 1'b1;
    localparam logic DOWN     = 1'b0;
    localparam logic ONE_SHOT = 1'b0;
    localparam logic PERIODIC = 1'b1;

    // Bit idx toggles when every lower bit is 1 (counting up) or 0 (counting down).
    function automatic logic count_toggle(input logic [31:0] q, input int idx, input logic up);
        logic all_match;
        all_match = 1'b1;
        for (int j = 0; j < 32; j++) begin
            if (j < idx) begin
                all_match = all_match & (up ? q[j] : ~q[j]);
            end
        end
        return all_match;
    endfunction

endpackage

// File: rtl/tff_sync_rst.sv
// Single T flip-flop with synchronous active-high reset.
module tff_sync_rst (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_count_seq.sv
// Start/stop/done sequencer driving a bank of T flip-flops as an up/down counter; every
// change to q, including loads and periodic reloads, is made by toggling q ^ target.
module tff_count_seq
    import tff_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tick
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] cnt_t;

    always_comb begin
        cnt_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_t[i] = count_toggle(32'(q), i, up_dn == UP);
        end
    end

    // stop outranks load_en and start in every state.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        tick_d  = 1'b0;
        t_vec   = '0;
        unique case (state_q)
            IDLE: begin
                if (!stop) begin
                    if (load_en) begin
                        t_vec  = q ^ load_val;
                        base_d = load_val;
                    end else if (start) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (q == limit) begin
                    if (mode == ONE_SHOT) begin
                        state_d = DONE;
                    end else begin
                        t_vec  = q ^ base_q;
                        tick_d = 1'b1;
                    end
                end else begin
                    t_vec = cnt_t;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            t_vec = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_sync_rst u_tff (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end

    assign busy = (state_q == RUN) || (state_q == HOLD);
    assign done = (state_q == DONE);
    assign tick = tick_q;

endmodule
